stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/lap/zero controller for the 50 MHz seconds stopwatch datapath: the
//  mod-50M prescaler (reached tick) feeding the 4-digit BCD counter on HEX0..HEX3.
//  Debounces three pushbuttons and sequences prescaler clear, count enable and count
//  clear. Muxes a lap snapshot onto the display bus. Sits between the board keys and
//  the prescaler/counter instances in the lab top level.
// PARAMETERS
//  SYNC_STAGES      2          synchroniser flops per button input (>=2)
//  DEBOUNCE_CYCLES  1000000    cycles a synced input must hold a new level (20 ms @ 50 MHz)
//  DB_W             20         debounce counter width; must hold DEBOUNCE_CYCLES-1
//  DATA_W           16         width of count/display bus (4 BCD digits)
// PORTS
//  Clkin       in   1       50 MHz clock, all logic rising-edge
//  clear       in   1       reset: asynchronous assert, active-low
//  btn_ss      in   1       start/stop button, raw, active-high
//  btn_lap     in   1       lap button, raw, active-high
//  btn_zero    in   1       zero button, raw, active-high
//  tick        in   1       prescaler reached pulse, 1 cycle
//  count_in    in   DATA_W  live counter value
//  pscl_clr    out  1       sync clear to prescaler, 1-cycle pulse
//  cnt_clr     out  1       sync clear to counter, 1-cycle pulse
//  count_en    out  1       increment strobe to counter
//  disp_val    out  DATA_W  value to 7-seg decoders
//  state_o     out  2       FSM state for LEDR: 00 IDLE, 01 RUN, 10 LAP, 11 PAUSE
// BEHAVIOUR
//  Reset (clear=0): state IDLE. Sync/debounce flops, debounce counters, stable levels
//   and lap_reg go to 0. pscl_clr=cnt_clr=0. count_en=0. disp_val=count_in.
//   Mid-operation reset aborts immediately. The counter and prescaler take the same
//   clear, so the block emits no clr pulse for this case.
//  Debounce, per button: SYNC_STAGES-flop synchroniser -> s.
//   Counter resets to 0 on any edge where s==stable, else increments.
//   On the edge where counter==DEBOUNCE_CYCLES-1 and s!=stable, stable<=s.
//   Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
//  Press event: comb. stable & ~stable_q, 1 cycle per press. Release produces no event.
//  Latency: a clean button rise changes state_o exactly SYNC_STAGES+DEBOUNCE_CYCLES+1
//   edges later.
//  FSM, registered. Only events in the listed transitions act; all others are ignored:
//   IDLE : ss   -> RUN,   pscl_clr pulse (first increment is a full period later).
//          zero -> IDLE,  cnt_clr pulse.
//   RUN  : ss   -> PAUSE.
//          lap  -> LAP,   lap_reg<=count_in.
//   LAP  : lap  -> RUN    (display back to live).
//          ss   -> PAUSE  (display back to live).
//   PAUSE: ss   -> RUN    (prescaler NOT cleared; resumes partial period).
//          zero -> IDLE,  cnt_clr and pscl_clr pulse.
//  Same-cycle events: priority ss > lap > zero. Only one transition per cycle.
//  pscl_clr/cnt_clr: registered, high the cycle after the accepting edge, 1 cycle wide.
//  count_en = tick & (state==RUN | state==LAP), combinational, no added latency.
//   A tick coincident with a leaving-RUN edge still counts; the state is pre-edge.
//  Lap snapshot: lap_reg takes count_in as sampled at the accepting edge
//   (pre-increment if count_en is high that cycle).
//  disp_val = (state==LAP) ? lap_reg : count_in. Counting continues underneath.
//  No counter wrap handling here: 9999->0000 wrap is owned by the counter.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1 Reset: clear=0 with buttons toggling -> state_o=00, all pulses 0,
//    disp_val==count_in. Release reset -> stays 00.
//  2 Debounce: btn_ss high 3 cycles, then 0 -> no state change.
//    btn_ss high 10 cycles -> state_o=01 exactly 7 edges after rise.
//    Exactly one pscl_clr pulse.
//  3 Count/lap: in RUN, 5 ticks -> 5 count_en pulses.
//    Lap press with count_in=0x0012 -> state 10, disp_val held 0x0012 while
//    count_in advances. Lap again -> state 01, disp_val live.
//  4 Pause/zero: RUN -> ss -> 11, ticks give count_en=0.
//    zero -> state 00, one cnt_clr + one pscl_clr.
//    zero in RUN -> ignored.
//  5 Simultaneous: ss and lap debounced on the same cycle in RUN -> state 11
//    (ss wins), lap_reg unchanged.
//  6 Async reset mid-LAP: clear low between edges -> state_o=00 before the next
//    edge, lap_reg=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/zero controller for the seconds stopwatch datapath.
// Debounces the three board keys, sequences prescaler clear, count enable and
// count clear, and muxes a lap snapshot onto the display bus.
// Ports: i_clkin    - 50 MHz clock, all logic rising-edge
//        i_clear    - asynchronous active-low reset
//        i_btn_ss / i_btn_lap / i_btn_zero - raw active-high pushbuttons
//        i_tick     - prescaler reached pulse (1 cycle)
//        i_count_in - live BCD counter value
//        o_pscl_clr / o_cnt_clr - registered 1-cycle clears to prescaler / counter
//        o_count_en - increment strobe to counter (tick gated by RUN/LAP)
//        o_disp_val - value to the 7-seg decoders (lap snapshot while in LAP)
//        o_state    - FSM state for LEDs: 00 IDLE, 01 RUN, 10 LAP, 11 PAUSE
module stopwatch_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int DATA_W          = 16
) (
  input  logic              i_clkin,
  input  logic              i_clear,
  input  logic              i_btn_ss,
  input  logic              i_btn_lap,
  input  logic              i_btn_zero,
  input  logic              i_tick,
  input  logic [DATA_W-1:0] i_count_in,
  output logic              o_pscl_clr,
  output logic              o_cnt_clr,
  output logic              o_count_en,
  output logic [DATA_W-1:0] o_disp_val,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_LAP   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  localparam int              NB      = 3;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button order in the vectors: bit0 start/stop, bit1 lap, bit2 zero.
  logic [NB-1:0] w_raw;
  logic [NB-1:0] w_press;

  assign w_raw = {i_btn_zero, i_btn_lap, i_btn_ss};

  for (genvar b = 0; b < NB; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_cnt;
    logic                   r_stable;
    logic                   r_stable_q;
    logic                   w_s;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_press[b] = r_stable & ~r_stable_q;

    always_ff @(posedge i_clkin or negedge i_clear) begin
      if (!i_clear) begin
        r_sync     <= '0;
        r_cnt      <= '0;
        r_stable   <= 1'b0;
        r_stable_q <= 1'b0;
      end else begin
        r_sync     <= {r_sync[SYNC_STAGES-2:0], w_raw[b]};
        r_stable_q <= r_stable;
        if (w_s == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          // Counter restarts on acceptance so a bounce straight after a new
          // level still has to hold for the full window to be taken.
          r_stable <= w_s;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end
    end
  end

  logic w_ev_ss, w_ev_lap, w_ev_zero;
  assign w_ev_ss   = w_press[0];
  assign w_ev_lap  = w_press[1];
  assign w_ev_zero = w_press[2];

  state_t            r_state, w_state_nxt;
  logic              r_pscl_clr, r_cnt_clr;
  logic              w_pscl_nxt, w_cnt_nxt, w_lap_ld;
  logic [DATA_W-1:0] r_lap_reg;

  // Priority ss > lap > zero falls out of the if/else order; events with no
  // transition in the current state are simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    w_pscl_nxt  = 1'b0;
    w_cnt_nxt   = 1'b0;
    w_lap_ld    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_ev_ss) begin
          w_state_nxt = S_RUN;
          w_pscl_nxt  = 1'b1;
        end else if (w_ev_zero) begin
          w_cnt_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (w_ev_ss) begin
          w_state_nxt = S_PAUSE;
        end else if (w_ev_lap) begin
          w_state_nxt = S_LAP;
          w_lap_ld    = 1'b1;
        end
      end
      S_LAP: begin
        if (w_ev_ss) begin
          w_state_nxt = S_PAUSE;
        end else if (w_ev_lap) begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        // Resume keeps the prescaler phase so the partial second is not lost.
        if (w_ev_ss) begin
          w_state_nxt = S_RUN;
        end else if (w_ev_zero) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 1'b1;
          w_pscl_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clkin or negedge i_clear) begin
    if (!i_clear) begin
      r_state    <= S_IDLE;
      r_pscl_clr <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_lap_reg  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pscl_clr <= w_pscl_nxt;
      r_cnt_clr  <= w_cnt_nxt;
      if (w_lap_ld) r_lap_reg <= i_count_in;
    end
  end

  // Uses the pre-edge state, so a tick on the edge that leaves RUN still counts.
  assign o_count_en = i_tick & ((r_state == S_RUN) | (r_state == S_LAP));
  assign o_disp_val = (r_state == S_LAP) ? r_lap_reg : i_count_in;
  assign o_pscl_clr = r_pscl_clr;
  assign o_cnt_clr  = r_cnt_clr;
  assign o_state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          btn_ss = 1'b0, btn_lap = 1'b0, btn_zero = 1'b0, tick = 1'b0;
  logic [DW-1:0] count_in = '0;
  logic          pscl_clr, cnt_clr, count_en;
  logic [DW-1:0] disp_val;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .DB_W(3), .DATA_W(DW)
  ) dut (
    .i_clkin(clk), .i_clear(clear),
    .i_btn_ss(btn_ss), .i_btn_lap(btn_lap), .i_btn_zero(btn_zero),
    .i_tick(tick), .i_count_in(count_in),
    .o_pscl_clr(pscl_clr), .o_cnt_clr(cnt_clr), .o_count_en(count_en),
    .o_disp_val(disp_val), .o_state(state_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A button level is accepted once the synchronised input has differed from
  // the accepted level on DEB consecutive edges; the synchronised input seen at
  // edge j is the raw level sampled at edge j-SYNC. A press is the edge after
  // the accepted level rises.
  int            m_state = 0;
  logic [DW-1:0] m_lap = '0;
  logic          m_pscl = 1'b0, m_cclr = 1'b0;
  logic [2:0]    m_stable = '0, m_stable_q = '0;
  logic [15:0]   m_hist [3] = '{default: '0};

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m_state = 0; m_lap = '0; m_pscl = 1'b0; m_cclr = 1'b0;
      m_stable = '0; m_stable_q = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
    end else begin
      logic [2:0] raw, ev;
      int         nxt;
      logic       np, nc, diff;
      raw = {btn_zero, btn_lap, btn_ss};
      ev  = m_stable & ~m_stable_q;
      nxt = m_state; np = 1'b0; nc = 1'b0;
      case (m_state)
        0: if (ev[0]) begin nxt = 1; np = 1'b1; end
           else if (ev[2]) nc = 1'b1;
        1: if (ev[0]) nxt = 3;
           else if (ev[1]) begin nxt = 2; m_lap = count_in; end
        2: if (ev[0]) nxt = 3;
           else if (ev[1]) nxt = 1;
        default: if (ev[0]) nxt = 1;
                 else if (ev[2]) begin nxt = 0; nc = 1'b1; np = 1'b1; end
      endcase
      m_state = nxt; m_pscl = np; m_cclr = nc;
      m_stable_q = m_stable;
      for (int b = 0; b < 3; b++) begin
        // m_hist[b][k] holds the raw level sampled k+1 edges ago
        diff = 1'b1;
        for (int k = SYNC - 1; k <= SYNC + DEB - 2; k++)
          if (m_hist[b][k] == m_stable[b]) diff = 1'b0;
        if (diff) m_stable[b] = ~m_stable[b];
        m_hist[b] = {m_hist[b][14:0], raw[b]};
      end
    end
  end

  int n_pscl = 0, n_cclr = 0, n_en = 0;

  always @(negedge clk) begin
    chk("state", {30'd0, state_o}, m_state);
    chk("pscl_clr", {31'd0, pscl_clr}, {31'd0, m_pscl});
    chk("cnt_clr", {31'd0, cnt_clr}, {31'd0, m_cclr});
    chk("count_en", {31'd0, count_en}, {31'd0, tick & (m_state == 1 || m_state == 2)});
    chk("disp_val", {16'd0, disp_val}, {16'd0, (m_state == 2) ? m_lap : count_in});
    n_pscl += int'(pscl_clr);
    n_cclr += int'(cnt_clr);
    n_en   += int'(count_en);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m: bit0 start/stop, bit1 lap, bit2 zero; held 10 cycles, then released
  task automatic press(input logic [2:0] m);
    {btn_zero, btn_lap, btn_ss} = m;
    step(10);
    {btn_zero, btn_lap, btn_ss} = 3'b000;
    step(8);
  endtask

  int p0, c0, e0;

  initial begin
    // 1: reset with buttons toggling
    for (int i = 0; i < 6; i++) begin
      step(1);
      btn_ss = i[0]; btn_lap = ~i[0]; btn_zero = i[1];
      count_in = 16'h0100 + DW'(i);
    end
    step(1);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_disp", {16'd0, disp_val}, 32'h0105);
    chk("rst_pulses", {30'd0, pscl_clr, cnt_clr}, 32'd0);
    {btn_zero, btn_lap, btn_ss} = 3'b000;
    count_in = 16'h0000;
    step(1);
    clear = 1'b1;
    step(10);
    chk("idle_after_rst", {30'd0, state_o}, 32'd0);

    // 2: short glitch ignored, clean press lands exactly 7 edges after the rise
    btn_ss = 1'b1; step(3); btn_ss = 1'b0; step(10);
    chk("glitch_state", {30'd0, state_o}, 32'd0);
    chk("glitch_pscl", n_pscl, 32'd0);
    btn_ss = 1'b1;
    step(6);
    chk("lat_edge6", {30'd0, state_o}, 32'd0);
    step(1);
    chk("lat_edge7", {30'd0, state_o}, 32'd1);
    chk("pscl_edge7", {31'd0, pscl_clr}, 32'd1);
    step(3); btn_ss = 1'b0; step(8);
    chk("one_pscl", n_pscl, 32'd1);

    // 3: counting and lap hold
    e0 = n_en;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; count_in = count_in + 1'b1; step(1);
      tick = 1'b0; step(1);
    end
    chk("run_en5", n_en - e0, 32'd5);
    count_in = 16'h0012;
    press(3'b010);
    chk("lap_state", {30'd0, state_o}, 32'd2);
    chk("lap_disp", {16'd0, disp_val}, 32'h0012);
    e0 = n_en;
    for (int i = 0; i < 4; i++) begin
      count_in = 16'h0013 + DW'(i); tick = 1'b1; step(1);
      chk("lap_hold", {16'd0, disp_val}, 32'h0012);
      tick = 1'b0;
    end
    step(1);
    chk("lap_en4", n_en - e0, 32'd4);
    press(3'b010);
    chk("unlap_state", {30'd0, state_o}, 32'd1);
    count_in = 16'h0020; #1;
    chk("unlap_live", {16'd0, disp_val}, 32'h0020);

    // 4: pause, zero from pause, zero in idle, zero ignored in run
    press(3'b001);
    chk("pause_state", {30'd0, state_o}, 32'd3);
    e0 = n_en;
    for (int i = 0; i < 3; i++) begin tick = 1'b1; step(1); tick = 1'b0; step(1); end
    chk("pause_en0", n_en - e0, 32'd0);
    p0 = n_pscl; c0 = n_cclr;
    press(3'b100);
    chk("zero_state", {30'd0, state_o}, 32'd0);
    chk("zero_cclr", n_cclr - c0, 32'd1);
    chk("zero_pscl", n_pscl - p0, 32'd1);
    p0 = n_pscl; c0 = n_cclr;
    press(3'b100);
    chk("idle_zero_cclr", n_cclr - c0, 32'd1);
    chk("idle_zero_pscl", n_pscl - p0, 32'd0);
    press(3'b001);
    c0 = n_cclr;
    press(3'b100);
    chk("run_zero_ign", {30'd0, state_o}, 32'd1);
    chk("run_zero_cclr", n_cclr - c0, 32'd0);

    // 5: ss and lap together in RUN -> PAUSE
    count_in = 16'h0055;
    press(3'b011);
    chk("simul_state", {30'd0, state_o}, 32'd3);
    chk("simul_disp", {16'd0, disp_val}, 32'h0055);

    // 6: asynchronous reset in the middle of LAP
    press(3'b001);
    count_in = 16'h0042;
    press(3'b010);
    chk("pre_rst_lap", {30'd0, state_o}, 32'd2);
    count_in = 16'h0043;
    @(negedge clk); #2;
    clear = 1'b0; #1;
    chk("async_state", {30'd0, state_o}, 32'd0);
    chk("async_disp", {16'd0, disp_val}, 32'h0043);
    step(2);
    clear = 1'b1;
    step(3);
    chk("post_rst_state", {30'd0, state_o}, 32'd0);
    press(3'b001);
    count_in = 16'h0099;
    press(3'b010);
    chk("relap_disp", {16'd0, disp_val}, 32'h0099);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
